// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: registered one-hot decoder with active-low enable and a dwell-timed scan sequencer
module decoder_scan_seq #(
  parameter int SEL_W = 4,
  parameter int DWELL = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [SEL_W-1:0] dec_in,
  input  logic [SEL_W-1:0] scan_last,
  output logic [OUT_W-1:0] dec_out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             wrap
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] sel_n;
  logic [OUT_W-1:0] dec_n;
  logic wrap_n, at_end;
  assign at_end = cur_sel >= scan_last;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = cur_sel;
    wrap_n = 1'b0;
    if (enable) begin
      state_n = IDLE;
      cnt_n = '0;
      sel_n = '0;
    end else if (!mode) begin
      state_n = DIRECT;
      cnt_n = '0;
      sel_n = dec_in;
    end else if (state != SCAN) begin
      state_n = SCAN;
      cnt_n = '0;
      sel_n = '0;
    end else if (cnt != LAST) begin
      cnt_n = cnt + 1'b1;
    end else begin
      cnt_n = '0;
      sel_n = at_end ? '0 : cur_sel + 1'b1;
      wrap_n = at_end;
    end
    dec_n = enable ? '0 : {{(OUT_W-1){1'b0}}, 1'b1} << sel_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      cur_sel <= '0;
      dec_out <= '0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cur_sel <= sel_n;
      dec_out <= dec_n;
      wrap <= wrap_n;
    end
  end
endmodule
